// File: rtl/gsquare_b.sv
// gsquare_b: unary (stochastic) squarer.
// A saturating up/down counter, compared against an external random number,
// regenerates a decorrelated copy of the input stream. The input is ANDed
// with that copy, so the output probability is about p*p.
// Optional build macro GSQUARE_CNT_OUT_EN exposes the counter (cnt_o) and
// its saturation flag (sat_o).
module gsquare_b #(
    parameter int unsigned BW   = 5,
    parameter int unsigned WARM = 6
) (
    input  logic          clk,
    input  logic          rst_n,      // active-high synchronous reset despite the name
    input  logic          in_valid,
    input  logic [BW:0]   rand_num,
    input  logic          in,
    output logic          out,
    output logic          out_valid
`ifdef GSQUARE_CNT_OUT_EN
    ,
    output logic [BW:0]   cnt_o,
    output logic          sat_o
`endif
);

    localparam int unsigned CW = BW + 1;
    localparam logic [CW-1:0]   CNT_MID   = CW'(1) << BW;
    localparam logic [CW-1:0]   CNT_MAX   = '1;
    localparam logic [CW-1:0]   CNT_MIN   = '0;
    localparam logic [WARM-1:0] WARM_LAST = '1;

    localparam logic [0:0] S_WARM = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [CW-1:0]   r_cnt;
    logic [WARM-1:0] r_warm_cnt;
    logic [0:0]      r_state;
    logic            r_out;
    logic            r_out_valid;

    logic            w_regen;
    logic [CW-1:0]   w_cnt_nxt;
    logic [WARM-1:0] w_warm_nxt;
    logic [0:0]      w_state_nxt;
    logic            w_out_nxt;
    logic            w_out_valid_nxt;

    // Regenerated copy of the input stream from the pre-update counter
    assign w_regen = (r_cnt > rand_num);

    // Next-state, counter and output decode
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_warm_nxt      = r_warm_cnt;
        w_state_nxt     = r_state;
        w_out_nxt       = 1'b0;
        w_out_valid_nxt = 1'b0;

        if (in_valid) begin
            if (in && !w_regen) begin
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end else if (!in && w_regen) begin
                if (r_cnt != CNT_MIN) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            case (r_state)
                S_WARM: begin
                    // The transition edge itself still emits an invalid output
                    w_warm_nxt = r_warm_cnt + WARM'(1);
                    if (r_warm_cnt == WARM_LAST) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    w_out_nxt       = in & w_regen;
                    w_out_valid_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = S_WARM;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt       <= CNT_MID;
            r_warm_cnt  <= '0;
            r_state     <= S_WARM;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_warm_cnt  <= w_warm_nxt;
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef GSQUARE_CNT_OUT_EN
    assign cnt_o = r_cnt;
    assign sat_o = (r_cnt == CNT_MIN) || (r_cnt == CNT_MAX);
`endif

endmodule

// File: tb/tb_gsquare_b.sv
// Directed bench for gsquare_b (BW=5, WARM=6).
module tb_gsquare_b;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] rand_num;
    logic       in;
    logic       out;
    logic       out_valid;
`ifdef GSQUARE_CNT_OUT_EN
    logic [5:0] cnt_o;
    logic       sat_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_cnt  = 32;
    int m_warm = 0;
    bit m_run  = 0;
    int e_out  = 0;
    int e_ov   = 0;

    gsquare_b #(.BW(5), .WARM(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .rand_num  (rand_num),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
`ifdef GSQUARE_CNT_OUT_EN
        ,
        .cnt_o     (cnt_o),
        .sat_o     (sat_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance reference, check after the edge
    task automatic step(input bit rst, input bit iv, input bit i, input int rn);
        bit regen;
        rst_n    = rst;
        in_valid = iv;
        in       = i;
        rand_num = 6'(rn);
        regen    = (m_cnt > rn);
        if (rst) begin
            m_cnt = 32; m_warm = 0; m_run = 0; e_out = 0; e_ov = 0;
        end else begin
            e_out = 0; e_ov = 0;
            if (iv) begin
                if (m_run) begin
                    e_ov  = 1;
                    e_out = (i && regen) ? 1 : 0;
                end
                if (i && !regen && m_cnt < 63) m_cnt = m_cnt + 1;
                else if (!i && regen && m_cnt > 0) m_cnt = m_cnt - 1;
                if (!m_run) begin
                    if (m_warm == 63) m_run = 1;
                    m_warm = (m_warm + 1) % 64;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out", 32'(out), 32'(e_out));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("cnt", 32'(dut.r_cnt), 32'(m_cnt));
`ifdef GSQUARE_CNT_OUT_EN
        chk("cnt_o", 32'(cnt_o), 32'(m_cnt));
        chk("sat_o", 32'(sat_o), (m_cnt == 0 || m_cnt == 63) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        int ones;
        logic [15:0] lfsr_a;
        logic [19:0] lfsr_b;

        rst_n = 1'b1; in_valid = 1'b0; in = 1'b0; rand_num = '0;

        // Reset for two cycles, then idle
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(dut.r_cnt), 32'd32);
        for (int k = 0; k < 100; k++) step(0, 0, $urandom_range(0, 1), $urandom_range(0, 63));
        chk("idle_cnt", 32'(dut.r_cnt), 32'd32);
        chk("idle_ov", 32'(out_valid), 32'd0);

        // Warm-up: in=1, rand sweeps; first valid output on the 65th valid edge
        ones = 0;
        for (int n = 1; n <= 128; n++) begin
            step(0, 1, 1, (n - 1) % 64);
            chk("warm_ov", 32'(out_valid), (n >= 65) ? 32'd1 : 32'd0);
            if (n == 64) chk("warm_cnt63", 32'(dut.r_cnt), 32'd63);
            if (n >= 65) ones += int'(out);
        end
        chk("sat_hi_ones", 32'(ones), 32'd63);
        // Saturated high: one more sweep, single zero at rand_num=63
        ones = 0;
        for (int n = 0; n < 64; n++) begin
            step(0, 1, 1, n);
            chk("sat_hi_bit", 32'(out), (n == 63) ? 32'd0 : 32'd1);
            ones += int'(out);
        end
        chk("sat_hi_ones2", 32'(ones), 32'd63);
        chk("sat_hi_cnt", 32'(dut.r_cnt), 32'd63);

        // Saturated low: in=0, rand=0 drains 63 -> 0 and holds
        for (int n = 0; n < 200; n++) begin
            step(0, 1, 0, 0);
            chk("sat_lo_out", 32'(out), 32'd0);
        end
        chk("sat_lo_cnt", 32'(dut.r_cnt), 32'd0);

        // Statistical: p=0.5 from LFSR A, rand from LFSR B
        lfsr_a = 16'hACE1;
        lfsr_b = 20'h5A3C7;
        ones = 0;
        for (int n = 0; n < 4096; n++) begin
            lfsr_a = lfsr_a[0] ? ((lfsr_a >> 1) ^ 16'hB400) : (lfsr_a >> 1);
            for (int s = 0; s < 6; s++)
                lfsr_b = lfsr_b[0] ? ((lfsr_b >> 1) ^ 20'h90000) : (lfsr_b >> 1);
            step(0, 1, lfsr_a[0], int'(lfsr_b[5:0]));
            ones += int'(out);
        end
        chk("stat_range", (ones >= 896 && ones <= 1152) ? 32'd1 : 32'd0, 32'd1);

        // Reach cnt=50 in RUN: saturate high, then 13 decrements
        for (int n = 0; n < 70; n++) step(0, 1, 1, 63);
        chk("pre_cnt63", 32'(dut.r_cnt), 32'd63);
        for (int n = 0; n < 13; n++) step(0, 1, 0, 0);
        chk("pre_cnt50", 32'(dut.r_cnt), 32'd50);

        // Mid-run reset with in_valid high overrides the update
        step(1, 1, 1, 63);
        chk("mrst_cnt", 32'(dut.r_cnt), 32'd32);
        chk("mrst_state", 32'(dut.r_state), 32'd0);
        chk("mrst_ov", 32'(out_valid), 32'd0);
        for (int n = 1; n <= 65; n++) begin
            step(0, 1, 1, 0);
            chk("rewarm_ov", 32'(out_valid), (n == 65) ? 32'd1 : 32'd0);
        end
        chk("rewarm_out", 32'(out), 32'd1);
        chk("rewarm_cnt", 32'(dut.r_cnt), 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
